// File: rtl/vga_gray_source.sv
// rtl/vga_gray_source.sv - 640x480 VGA timing with frame-buffer fetch and RGB444-to-gray conversion
// Two-stage pipeline: stage 1 issues the buffer read, stage 2 converts and registers all outputs.
module vga_gray_source #(
  parameter int         H_ACTIVE    = 640,
  parameter int         H_FP        = 16,
  parameter int         H_SYNC      = 96,
  parameter int         H_BP        = 48,
  parameter int         V_ACTIVE    = 480,
  parameter int         V_FP        = 10,
  parameter int         V_SYNC      = 2,
  parameter int         V_BP        = 33,
  parameter logic       SYNC_POL    = 1'b0,
  parameter int         FB_W        = 320,
  parameter int         FB_H        = 240,
  parameter int         SCALE_SHIFT = 1,
  parameter logic [7:0] BG_GRAY     = 8'h00,
  parameter int         AW          = 17
) (
  input  logic          vga_clk,
  input  logic          rst,
  output logic          fb_rd_en,
  output logic [AW-1:0] fb_rd_addr,
  input  logic [11:0]   fb_rd_data,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [9:0]    pos_x,
  output logic [9:0]    pos_y,
  output logic [7:0]    gray,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [9:0] hcnt, vcnt;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else if (hcnt == 10'(H_TOTAL - 1)) begin
      hcnt <= 10'd0;
      vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  logic          active0, inwin0, hs0, vs0, fs0;
  logic [9:0]    fx0, fy0;
  logic [AW-1:0] addr0;

  always_comb begin
    active0 = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    fx0     = hcnt >> SCALE_SHIFT;
    fy0     = vcnt >> SCALE_SHIFT;
    inwin0  = active0 && (int'(fx0) < FB_W) && (int'(fy0) < FB_H);
    addr0   = AW'(fy0) * AW'(FB_W) + AW'(fx0);
    hs0     = (int'(hcnt) >= HS_START && int'(hcnt) < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs0     = (int'(vcnt) >= VS_START && int'(vcnt) < VS_END) ? SYNC_POL : ~SYNC_POL;
    fs0     = (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  logic       s1_active, s1_hs, s1_vs, s1_fs;
  logic [9:0] s1_x, s1_y;

  // fb_rd_en doubles as the stage-1 in-window flag for the pixel in flight
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
      s1_active  <= 1'b0;
      s1_hs      <= ~SYNC_POL;
      s1_vs      <= ~SYNC_POL;
      s1_fs      <= 1'b0;
      s1_x       <= 10'd0;
      s1_y       <= 10'd0;
    end else begin
      fb_rd_en  <= inwin0;
      if (inwin0) fb_rd_addr <= addr0;
      s1_active <= active0;
      s1_hs     <= hs0;
      s1_vs     <= vs0;
      s1_fs     <= fs0;
      s1_x      <= hcnt;
      s1_y      <= vcnt;
    end
  end

  logic [7:0]  r8, g8, b8;
  logic [15:0] luma;

  // Nibble replication is the exact x17 expansion; weights sum to 256 so 16 bits never overflow
  always_comb begin
    r8   = {fb_rd_data[11:8], fb_rd_data[11:8]};
    g8   = {fb_rd_data[7:4],  fb_rd_data[7:4]};
    b8   = {fb_rd_data[3:0],  fb_rd_data[3:0]};
    luma = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      pos_x       <= 10'd0;
      pos_y       <= 10'd0;
      gray        <= 8'd0;
    end else begin
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      de          <= s1_active;
      frame_start <= s1_fs;
      // Blanking keeps the last active pixel so downstream line buffers stay intact
      if (s1_active) begin
        pos_x <= s1_x;
        pos_y <= s1_y;
        gray  <= fb_rd_en ? 8'(luma >> 8) : BG_GRAY;
      end
    end
  end

endmodule

// File: tb/tb_vga_gray_source.sv
// tb/tb_vga_gray_source.sv - randomized model-based bench for vga_gray_source
// Three instances: default timing, narrow buffer, and a shrunken raster for whole-frame checks.
module tb_vga_gray_source;

  localparam int NI = 3;
  localparam int HA  [NI] = '{640, 640, 40};
  localparam int HF  [NI] = '{16, 16, 4};
  localparam int HSW [NI] = '{96, 96, 8};
  localparam int HB  [NI] = '{48, 48, 6};
  localparam int VA  [NI] = '{480, 480, 30};
  localparam int VF  [NI] = '{10, 10, 2};
  localparam int VSW [NI] = '{2, 2, 2};
  localparam int VB  [NI] = '{33, 33, 3};
  localparam int FBW [NI] = '{320, 160, 16};
  localparam int FBH [NI] = '{240, 240, 12};
  localparam int SH  [NI] = '{1, 1, 1};
  localparam int POL [NI] = '{0, 0, 1};
  localparam int BG  [NI] = '{0, 8'h11, 8'h40};

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic                  rst;
  logic [NI-1:0][11:0]   rdata;
  wire  [NI-1:0]         en, hs, vs, de, fs;
  wire  [NI-1:0][16:0]   addr;
  wire  [NI-1:0][9:0]    px, py;
  wire  [NI-1:0][7:0]    gr;

  vga_gray_source u_a (
    .vga_clk(vga_clk), .rst(rst), .fb_rd_en(en[0]), .fb_rd_addr(addr[0]), .fb_rd_data(rdata[0]),
    .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .pos_x(px[0]), .pos_y(py[0]), .gray(gr[0]),
    .frame_start(fs[0])
  );

  vga_gray_source #(.FB_W(160), .BG_GRAY(8'h11)) u_b (
    .vga_clk(vga_clk), .rst(rst), .fb_rd_en(en[1]), .fb_rd_addr(addr[1]), .fb_rd_data(rdata[1]),
    .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .pos_x(px[1]), .pos_y(py[1]), .gray(gr[1]),
    .frame_start(fs[1])
  );

  vga_gray_source #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6), .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .FB_W(16), .FB_H(12), .BG_GRAY(8'h40)
  ) u_c (
    .vga_clk(vga_clk), .rst(rst), .fb_rd_en(en[2]), .fb_rd_addr(addr[2]), .fb_rd_data(rdata[2]),
    .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .pos_x(px[2]), .pos_y(py[2]), .gray(gr[2]),
    .frame_start(fs[2])
  );

  logic [11:0] mem [0:131071];
  logic [11:0] pat [5] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h000};
  int          pat_gray [5] = '{255, 76, 149, 28, 0};

  int n_cnt = 0;
  bit seen_rst = 1'b0;
  bit mid_done = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge vga_clk) begin
    if (rst) begin
      n_cnt    <= 0;
      seen_rst <= 1'b1;
    end else begin
      n_cnt <= n_cnt + 1;
    end
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int lum(input logic [11:0] d);
    int r, g, b;
    r = int'(d[11:8]) * 17;
    g = int'(d[7:4]) * 17;
    b = int'(d[3:0]) * 17;
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  // Geometry of raster pixel p (counted from the first pixel after reset) for instance i
  task automatic pix(input int i, input int p, output bit act, output bit win, output int a,
                     output bit hsv, output bit vsv, output bit fsv, output int x, output int y);
    int ht, vt;
    ht  = HA[i] + HF[i] + HSW[i] + HB[i];
    vt  = VA[i] + VF[i] + VSW[i] + VB[i];
    x   = p % ht;
    y   = (p / ht) % vt;
    act = (x < HA[i]) && (y < VA[i]);
    win = act && ((x >> SH[i]) < FBW[i]) && ((y >> SH[i]) < FBH[i]);
    a   = (y >> SH[i]) * FBW[i] + (x >> SH[i]);
    hsv = (x >= HA[i] + HF[i] && x < HA[i] + HF[i] + HSW[i]) ? POL[i][0] : !POL[i][0];
    vsv = (y >= VA[i] + VF[i] && y < VA[i] + VF[i] + VSW[i]) ? POL[i][0] : !POL[i][0];
    fsv = (p % (ht * vt)) == 0;
  endtask

  initial begin
    int hx [NI], hy [NI], hg [NI], ha [NI];
    int n, x, y, a, hs_a, de_a, last_fs, vs_c;
    bit act, win, hsv, vsv, fsv, line_a;
    bit e_en, e_hs, e_vs, e_de, e_fs;
    logic [63:0] got, exp;
    line_a = 1'b0; last_fs = -1; vs_c = 0; hs_a = 0; de_a = 0;
    forever begin
      @(negedge vga_clk);
      if (seen_rst) begin
        n = n_cnt;
        for (int i = 0; i < NI; i++) begin
          if (n == 0) begin
            hx[i] = 0; hy[i] = 0; hg[i] = 0; ha[i] = 0;
          end
          e_en = 1'b0;
          if (n >= 1) begin
            pix(i, n - 1, act, win, a, hsv, vsv, fsv, x, y);
            e_en = win;
            if (win) ha[i] = a;
          end
          if (n >= 2) begin
            pix(i, n - 2, act, win, a, hsv, vsv, fsv, x, y);
            e_hs = hsv; e_vs = vsv; e_de = act; e_fs = fsv;
            if (act) begin
              hx[i] = x; hy[i] = y;
              hg[i] = win ? lum(mem[a]) : BG[i];
            end
          end else begin
            e_hs = !POL[i][0]; e_vs = !POL[i][0]; e_de = 1'b0; e_fs = 1'b0;
          end
          got = {14'd0, hs[i], vs[i], de[i], fs[i], en[i], addr[i], px[i], py[i], gr[i]};
          exp = {14'd0, e_hs, e_vs, e_de, e_fs, e_en, 17'(ha[i]), 10'(hx[i]), 10'(hy[i]), 8'(hg[i])};
          chk(got == exp, $sformatf("model inst%0d n=%0d", i, n), got, exp);
        end

        // Per-line sync/enable counts on the full-size raster
        if (n == 0) line_a = 1'b0;
        if (n >= 2) begin
          x = (n - 2) % 800;
          y = ((n - 2) / 800) % 525;
          if (x == 0) begin
            line_a = 1'b1; hs_a = 0; de_a = 0;
          end
          if (hs[0] == 1'b0) hs_a++;
          if (de[0]) de_a++;
          if (x == 799 && line_a) begin
            chk(hs_a == 96, "hsync_width", 64'(hs_a), 64'd96);
            chk(de_a == ((y < 480) ? 640 : 0), "de_per_line", 64'(de_a), (y < 480) ? 64'd640 : 64'd0);
          end
        end

        // Whole-frame period and vsync width on the shrunken raster (58 x 37)
        if (n == 0) begin
          last_fs = -1; vs_c = 0;
        end
        if (n >= 2) begin
          if (vs[2] == 1'b1) vs_c++;
          if (fs[2]) begin
            if (last_fs >= 0) begin
              chk(n - last_fs == 2146, "frame_period", 64'(n - last_fs), 64'd2146);
              chk(vs_c == 116, "vsync_width", 64'(vs_c), 64'd116);
            end
            last_fs = n; vs_c = 0;
          end
        end

        for (int k = 0; k < 5; k++)
          if (n == 2 + 2 * k)
            chk(gr[0] == 8'(pat_gray[k]), $sformatf("pattern_gray%0d", k), 64'(gr[0]), 64'(pat_gray[k]));
        if (n == 2) chk(fs[0] == 1'b1, "first_frame_start", 64'(fs[0]), 64'd1);
        if (n == 802) chk({en[0], addr[0]} == 18'h20000, "addr_1_1", 64'({en[0], addr[0]}), 64'h20000);
        if (n >= 8642 && n <= 8801)
          chk({px[0], py[0], gr[0]} == {10'd639, 10'd10, 8'h5A}, "blank_hold",
              64'({px[0], py[0], gr[0]}), 64'({10'd639, 10'd10, 8'h5A}));
        if (n == 332) chk({de[1], gr[1]} == {1'b1, 8'h11}, "narrow_bg", 64'({de[1], gr[1]}), 64'h111);
        if (n == 641) chk(de[1] == 1'b1, "narrow_de_639", 64'(de[1]), 64'd1);
        if (n == 401) chk(en[1] == 1'b0, "narrow_no_read", 64'(en[1]), 64'd0);
        if (n == 0 && mid_done)
          chk({hs[0], vs[0], de[0], fs[0], en[0], addr[0], px[0], py[0], gr[0]} == {2'b11, 48'd0},
              "mid_reset_values", 64'({hs[0], vs[0], de[0], fs[0], en[0], addr[0], px[0], py[0], gr[0]}),
              64'({2'b11, 48'd0}));
      end
      for (int i = 0; i < NI; i++)
        rdata[i] = en[i] ? mem[addr[i]] : 12'($urandom);
    end
  end

  initial begin
    for (int a = 0; a < 131072; a++) mem[a] = 12'($urandom);
    for (int a = 0; a < 320; a++) mem[a] = pat[a % 5];
    mem[1919] = 12'h183;
    rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge vga_clk);
    rst = 1'b0;
    for (int k = 0; k < 20000 && n_cnt != 16300; k++) @(negedge vga_clk);
    chk(n_cnt == 16300, "reach_mid_frame", 64'(n_cnt), 64'd16300);
    rst = 1'b1;
    mid_done = 1'b1;
    @(negedge vga_clk);
    rst = 1'b0;
    repeat (40000) @(negedge vga_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
